log_req_scheduler: RTL and testbench

//  Shares one log evaluator (48b u0 in, 31b e out, fixed latency, no stall) among N_REQ

---
 rtl/log_pkg.sv | 29 ++
 rtl/log_rsp_fifo.sv | 56 +++++
 rtl/log_req_scheduler.sv | 168 ++++++++++++++++
 tb/tb_log_req_scheduler.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/log_pkg.sv
// Shared types and constants for the log evaluator scheduler.
// Tag travels alongside each u0 through the evaluator latency.
package log_pkg;

  localparam int U0_W = 48;
  localparam int E_W = 31;
  localparam int ID_MAX_W = 3;
  localparam logic [U0_W-1:0] U0_ZERO_SUB = 48'h1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic                vld;
    logic [ID_MAX_W-1:0] id;
    logic                zero;
  } tag_t;

  // log(0) is undefined, so a zero operand is replaced
  function automatic logic [U0_W-1:0] u0_sub(
    input logic [U0_W-1:0] u
  );
    return (u == '0) ? U0_ZERO_SUB : u;
  endfunction

endpackage

// File: rtl/log_rsp_fifo.sv
// Synchronous first-word-fall-through result FIFO.
// Head is read straight from the storage registers.
module log_rsp_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [W-1:0]           i_wdata,
  input  logic                   i_pop,
  output logic                   o_valid,
  output logic [W-1:0]           o_rdata,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0] r_cnt;
  logic w_do_pop;
  logic w_full;

  assign w_do_pop = i_pop & (r_cnt != '0);
  assign w_full = (r_cnt == (AW+1)'(DEPTH));
  assign o_valid = (r_cnt != '0);
  assign o_rdata = r_mem[r_rp];
  assign o_count = r_cnt;

  // Storage write; contents need no reset
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wp] <= i_wdata;
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wp <= r_wp + 1'b1;
      if (w_do_pop) r_rp <= r_rp + 1'b1;
      if (i_push && !w_do_pop) r_cnt <= r_cnt + 1'b1;
      else if (!i_push && w_do_pop) r_cnt <= r_cnt - 1'b1;
    end
  end

  a_no_ovf: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(i_push && w_full && !i_pop)
  );

endmodule

// File: rtl/log_req_scheduler.sv
// Round-robin sharing of one fixed-latency log evaluator
// among N_REQ lanes, with tagged, credit-guarded result return.
module log_req_scheduler
  import log_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int ID_W        = 2,
  parameter int LOG_LATENCY = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*U0_W-1:0]   req_u0,
  output logic [N_REQ-1:0]        req_ready,
  output logic [U0_W-1:0]         log_u0,
  input  logic [E_W-1:0]          log_e,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [E_W-1:0]          rsp_e,
  output logic [ID_W-1:0]         rsp_id,
  output logic                    rsp_zero,
  output logic                    busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int IF_W = $clog2(LOG_LATENCY + 2);
  localparam int DW = E_W + ID_W + 1;

  state_e r_state;
  state_e w_state_nxt;
  logic w_run;
  logic [ID_W-1:0] r_rr;
  logic [IF_W-1:0] r_inflight;
  tag_t r_pipe [LOG_LATENCY+1];
  tag_t w_new_tag;
  logic [CNT_W-1:0] w_fifo_cnt;
  logic w_credit;
  logic w_found;
  logic w_issue;
  logic w_cap;
  logic w_pop;
  logic [ID_W-1:0] w_win;
  logic [U0_W-1:0] w_win_u0;
  logic [DW-1:0] w_wdata;
  logic [DW-1:0] w_rdata;
  logic [ID_MAX_W-1:0] w_unused_id;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_state_nxt;
  end

  // Next state; re-enable beats drain completion
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (en) w_state_nxt = S_RUN;
      S_RUN: if (!en) w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (en) w_state_nxt = S_RUN;
        else if (r_inflight == '0 && w_fifo_cnt == '0)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM-derived outputs
  always_comb begin
    w_run = (r_state == S_RUN);
    busy = (r_state != S_IDLE) | (r_inflight != '0)
         | (w_fifo_cnt != '0);
  end

  // Round-robin search starting at r_rr
  always_comb begin
    int idx;
    idx = 0;
    w_found = 1'b0;
    w_win = '0;
    w_win_u0 = '0;
    for (int o = 0; o < N_REQ; o++) begin
      idx = (int'(r_rr) + o) % N_REQ;
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_win = idx[ID_W-1:0];
        w_win_u0 = req_u0[idx*U0_W +: U0_W];
      end
    end
  end

  // Credits cover both buffered and in-flight results
  assign w_credit =
    (int'(w_fifo_cnt) + int'(r_inflight)) < FIFO_DEPTH;
  assign w_issue = w_run & w_credit & w_found;

  // One-hot grant
  always_comb begin
    req_ready = '0;
    if (w_issue) req_ready[w_win] = 1'b1;
  end

  // Tag for the operand being issued
  always_comb begin
    w_new_tag = '0;
    w_new_tag.vld = 1'b1;
    w_new_tag.id = ID_MAX_W'(w_win);
    w_new_tag.zero = (w_win_u0 == '0);
  end

  // Pointer and evaluator operand update on transfer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr <= '0;
      log_u0 <= '0;
    end else if (w_issue) begin
      r_rr <= (int'(w_win) == N_REQ - 1) ? '0 : w_win + 1'b1;
      log_u0 <= u0_sub(w_win_u0);
    end
  end

  // Tag pipe tracking evaluator latency
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i <= LOG_LATENCY; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= w_issue ? w_new_tag : '0;
      for (int i = 1; i <= LOG_LATENCY; i++)
        r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign w_cap = r_pipe[LOG_LATENCY].vld;
  assign w_unused_id = r_pipe[LOG_LATENCY].id;
  assign w_wdata = {log_e, r_pipe[LOG_LATENCY].id[ID_W-1:0],
                    r_pipe[LOG_LATENCY].zero};

  // In-flight count of valid tags
  always_ff @(posedge clk) begin
    if (!rst_n) r_inflight <= '0;
    else if (w_issue && !w_cap) r_inflight <= r_inflight + 1'b1;
    else if (!w_issue && w_cap) r_inflight <= r_inflight - 1'b1;
  end

  assign w_pop = rsp_valid & rsp_ready;

  log_rsp_fifo #(
    .W(DW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .i_push(w_cap),
    .i_wdata(w_wdata),
    .i_pop(w_pop),
    .o_valid(rsp_valid),
    .o_rdata(w_rdata),
    .o_count(w_fifo_cnt)
  );

  assign rsp_e = w_rdata[DW-1 -: E_W];
  assign rsp_id = w_rdata[ID_W:1];
  assign rsp_zero = w_rdata[0];

endmodule

// File: tb/tb_log_req_scheduler.sv
// Randomised scoreboard bench for log_req_scheduler.
// Reference: ideal evaluator delay line plus queue model.
module tb_log_req_scheduler;

  localparam int N = 4;
  localparam int L = 1;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic [N-1:0] req_valid;
  logic [N*48-1:0] req_u0;
  logic [N-1:0] req_ready;
  logic [47:0] log_u0;
  logic [30:0] log_e;
  logic rsp_valid;
  logic rsp_ready;
  logic [30:0] rsp_e;
  logic [1:0] rsp_id;
  logic rsp_zero;
  logic busy;

  always #5 clk = ~clk;

  log_req_scheduler #(
    .N_REQ(N), .ID_W(2), .LOG_LATENCY(L), .FIFO_DEPTH(D)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req_valid(req_valid), .req_u0(req_u0),
    .req_ready(req_ready), .log_u0(log_u0),
    .log_e(log_e), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_e(rsp_e),
    .rsp_id(rsp_id), .rsp_zero(rsp_zero),
    .busy(busy)
  );

  function automatic logic [30:0] fe(input logic [47:0] u);
    return (u[47:17] ^ u[30:0]) + 31'h2A5A5A5;
  endfunction

  function automatic logic [47:0] sub0(input logic [47:0] u);
    return (u == 48'h0) ? 48'h1 : u;
  endfunction

  // Ideal evaluator: fixed delay line
  logic [47:0] hist [L];
  always @(posedge clk) begin
    hist[0] <= log_u0;
    for (int i = 1; i < L; i++) hist[i] <= hist[i-1];
  end
  assign log_e = fe(hist[L-1]);

  typedef struct {
    logic [30:0] e;
    logic [1:0] id;
    logic zero;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_bad = 0;
  int n_grant = 0;
  int lane_cnt [N];

  bit m_run = 0;
  int m_rr = 0;
  int m_out = 0;
  logic [47:0] m_u0 = '0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model step, evaluated before the coming edge
  task automatic model_step();
    logic [N-1:0] exp_rdy;
    int lane;
    exp_t x;
    if (!rst_n) begin
      m_run = 0; m_rr = 0; m_out = 0; m_u0 = '0;
      sb.delete();
      return;
    end
    chk("log_u0", log_u0, m_u0);
    exp_rdy = '0;
    lane = -1;
    if (m_run && m_out < D)
      for (int o = 0; o < N; o++)
        if (lane < 0 && req_valid[(m_rr + o) % N])
          lane = (m_rr + o) % N;
    if (lane >= 0) exp_rdy[lane] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    if (lane >= 0) begin
      x.e = fe(sub0(req_u0[lane*48 +: 48]));
      x.id = lane[1:0];
      x.zero = (req_u0[lane*48 +: 48] == 48'h0);
      sb.push_back(x);
      m_u0 = sub0(req_u0[lane*48 +: 48]);
      m_rr = (lane + 1) % N;
      m_out++;
      n_grant++;
    end
    if (rsp_valid && rsp_ready) m_out--;
    m_run = en;
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((sb.size() != 0 || rsp_valid) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      n_bad++;
      $display("FAIL %s: drain timeout, %0d left", nm, sb.size());
    end
  endtask

  // Monitor: compares each delivered response
  always @(negedge clk) begin
    exp_t x;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL stale_rsp: got id %0d e %0h expected none",
                 rsp_id, rsp_e);
      end else begin
        x = sb.pop_front();
        chk("rsp_e", rsp_e, x.e);
        chk("rsp_id", rsp_id, x.id);
        chk("rsp_zero", rsp_zero, x.zero);
        lane_cnt[rsp_id]++;
      end
    end
  end

  task automatic all_lanes_rand();
    for (int i = 0; i < N; i++)
      req_u0[i*48 +: 48] = {$urandom, $urandom} & 48'hFFFFFFFFFFFF;
  endtask

  initial begin
    int n;
    rst_n = 0; en = 0; req_valid = '0; req_u0 = '0;
    rsp_ready = 0;
    for (int i = 0; i < N; i++) lane_cnt[i] = 0;
    @(posedge clk); #1;
    repeat (3) tick();
    rst_n = 1;
    tick();
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_busy", busy, 0);

    // Single request on lane 0, latency check
    en = 1; rsp_ready = 1;
    tick();
    req_valid = 4'b0001;
    req_u0[0 +: 48] = 48'h800000000000;
    n_grant = 0;
    tick();
    chk("single_grant", n_grant, 1);
    req_valid = '0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    chk("single_latency", n, L + 1);
    drain("single");

    // All lanes every cycle
    for (int i = 0; i < N; i++) lane_cnt[i] = 0;
    n_grant = 0;
    req_valid = 4'hF;
    for (int c = 0; c < 16; c++) begin
      all_lanes_rand();
      tick();
    end
    req_valid = '0;
    chk("full_rate_grants", n_grant, 16);
    drain("full_rate");
    for (int i = 0; i < N; i++)
      chk("lane_count", lane_cnt[i], 4);

    // Back-pressure: credit limit
    rsp_ready = 0;
    n_grant = 0;
    req_valid = 4'hF;
    for (int c = 0; c < 10; c++) begin
      all_lanes_rand();
      tick();
    end
    chk("credit_grants", n_grant, D);
    rsp_ready = 1;
    for (int c = 0; c < 8; c++) begin
      all_lanes_rand();
      tick();
    end
    req_valid = '0;
    drain("credit");

    // Zero operand on lane 2
    req_valid = 4'b0100;
    req_u0[2*48 +: 48] = 48'h0;
    tick();
    req_valid = '0;
    chk("zero_log_u0", log_u0, 48'h1);
    drain("zero");

    // Drop enable with two in flight
    n_grant = 0;
    req_valid = 4'b0011;
    all_lanes_rand();
    tick();
    en = 0;
    req_valid = 4'hF;
    tick();
    chk("drain_busy", busy, 1);
    for (int c = 0; c < 6; c++) tick();
    chk("drain_grants", n_grant, 2);
    req_valid = '0;
    drain("drain");
    tick(); tick();
    chk("drain_idle_busy", busy, 0);

    // Reset with 3 buffered and 1 in flight
    en = 1; rsp_ready = 0;
    tick();
    n_grant = 0;
    req_valid = 4'hF;
    all_lanes_rand();
    repeat (4) tick();
    req_valid = '0;
    tick();
    chk("pre_reset_grants", n_grant, 4);
    rst_n = 0;
    tick();
    chk("post_reset_rsp_valid", rsp_valid, 0);
    rst_n = 1; rsp_ready = 1;
    repeat (10) tick();
    chk("post_reset_rsp_valid2", rsp_valid, 0);

    // Randomised traffic
    for (int c = 0; c < 400; c++) begin
      en = ($urandom_range(0, 15) != 0);
      req_valid = 4'($urandom);
      rsp_ready = ($urandom_range(0, 9) < 7);
      all_lanes_rand();
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0) req_u0[i*48 +: 48] = '0;
      tick();
    end
    en = 1; req_valid = '0; rsp_ready = 1;
    drain("random");
    chk("final_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
